// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and the 4:4:4 RGB pixel type.
package vga_pkg;
  localparam int PIX_W          = 12;
  localparam int PIX_FIFO_DEPTH = 16;

  typedef logic [PIX_W-1:0] rgb_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// First-word-fall-through pixel FIFO between vga_frame and vga_sync, flushed on mode change.
// Define VGA_PIX_FIFO_STATS_EN to add underrun counter and high-water-mark outputs.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter  int DEPTH  = PIX_FIFO_DEPTH,
  parameter  int DATA_W = PIX_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_pix_rgb_valid,
  output logic              o_pix_rgb_ready,
  input  logic [DATA_W-1:0] i_pix_rgb_data,
  output logic              o_pix_rgb_valid,
  input  logic              i_pix_rgb_ready,
  output logic [DATA_W-1:0] o_pix_rgb_data,
  output logic [CNT_W-1:0]  o_level,
`ifdef VGA_PIX_FIFO_STATS_EN
  output logic [15:0]       o_underrun_cnt,
  output logic [CNT_W-1:0]  o_max_level,
`endif
  output logic              o_underrun
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              rst_q, full, empty, push, pop, underrun_nxt;

  assign full            = (count == CNT_W'(DEPTH));
  assign empty           = (count == '0);
  assign o_pix_rgb_ready = rst_q & ~full;
  assign o_pix_rgb_valid = ~empty;
  assign o_pix_rgb_data  = empty ? '0 : mem[rd_ptr];
  assign o_level         = count;
  assign push            = i_pix_rgb_valid & o_pix_rgb_ready;
  assign pop             = o_pix_rgb_valid & i_pix_rgb_ready;

  // NOTE: every variable gets a default before the ifs, so no path leaves one unassigned (no latch).
  always_comb begin
    count_nxt    = count;
    underrun_nxt = i_pix_rgb_ready & empty;
    if (i_flush) begin
      count_nxt    = '0;
      underrun_nxt = 1'b0;
    end else if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Holds off the producer for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_underrun <= 1'b0;
    end else begin
      count      <= count_nxt;
      o_underrun <= underrun_nxt;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately unreset so it maps to distributed RAM; count masks stale words.
  always_ff @(posedge clk) begin
    if (push && !i_flush) mem[wr_ptr] <= i_pix_rgb_data;
  end

`ifdef VGA_PIX_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_underrun_cnt <= '0;
      o_max_level    <= '0;
    end else if (i_flush) begin
      o_underrun_cnt <= '0;
      o_max_level    <= '0;
    end else begin
      if (underrun_nxt && o_underrun_cnt != 16'hFFFF) o_underrun_cnt <= o_underrun_cnt + 1'b1;
      if (count_nxt > o_max_level)                    o_max_level    <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pix_fifo.sv
// Self-checking bench for vga_pix_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_vga_pix_fifo;
  import vga_pkg::*;

  localparam int DEPTH = PIX_FIFO_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_flush = 1'b0;
  logic             vin = 1'b0;
  logic             rin = 1'b0;
  rgb_t             din = '0;
  logic             o_ready, o_valid, o_underrun;
  rgb_t             o_data;
  logic [CNT_W-1:0] o_level;
`ifdef VGA_PIX_FIFO_STATS_EN
  logic [15:0]      o_underrun_cnt;
  logic [CNT_W-1:0] o_max_level;
`endif

  vga_pix_fifo dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (i_flush),
    .i_pix_rgb_valid (vin),
    .o_pix_rgb_ready (o_ready),
    .i_pix_rgb_data  (din),
    .o_pix_rgb_valid (o_valid),
    .i_pix_rgb_ready (rin),
    .o_pix_rgb_data  (o_data),
    .o_level         (o_level),
`ifdef VGA_PIX_FIFO_STATS_EN
    .o_underrun_cnt  (o_underrun_cnt),
    .o_max_level     (o_max_level),
`endif
    .o_underrun      (o_underrun)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_pass  = 0;
  string phase   = "init";

  // Reference model: buffer contents as a queue plus the few flags the interface exposes.
  rgb_t q[$];
  bit   rst_done;
  bit   und;
  int   und_cnt;
  int   max_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    rst_done = 1'b0;
    und      = 1'b0;
    und_cnt  = 0;
    max_lvl  = 0;
  endtask

  task automatic check_outputs();
    check("valid",    32'(o_valid),    32'(q.size() != 0));
    check("ready",    32'(o_ready),    32'(rst_done && q.size() < DEPTH));
    check("data",     32'(o_data),     (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check("level",    32'(o_level),    32'(q.size()));
    check("underrun", 32'(o_underrun), 32'(und));
`ifdef VGA_PIX_FIFO_STATS_EN
    check("und_cnt",  32'(o_underrun_cnt), 32'(und_cnt));
    check("max_lvl",  32'(o_max_level),    32'(max_lvl));
`endif
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit push, pop;
    @(negedge clk);
    check_outputs();
    push = vin && rst_done && (q.size() < DEPTH);
    pop  = rin && (q.size() != 0);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      rst_done = 1'b1;
      if (i_flush) begin
        q.delete();
        und     = 1'b0;
        und_cnt = 0;
        max_lvl = 0;
      end else begin
        und = rin && (q.size() == 0);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(din);
        if (und && und_cnt < 65535) und_cnt++;
        if (q.size() > max_lvl) max_lvl = q.size();
      end
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    phase = "reset";
    repeat (5) step();
    rst_n = 1'b1;
    step();
    step();

    phase = "fill";
    rin = 1'b0;
    vin = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      din = rgb_t'(i);
      step();
    end
    check("level_full", 32'(o_level), 32'd16);

    phase = "drain";
    vin = 1'b0;
    rin = 1'b1;
    repeat (20) step();

    phase = "stream";
    rin = 1'b0;
    vin = 1'b1;
    for (int i = 0; i < 108; i++) begin
      din = rgb_t'(12'h100 + i);
      if (i == 8) rin = 1'b1;
      step();
    end
    check("level_stream", 32'(o_level), 32'd8);

    phase = "flush";
    vin = 1'b1;
    rin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = rgb_t'(12'h300 + i);
      step();
    end
    rin = 1'b1;
    i_flush = 1'b1;
    din = rgb_t'(12'hABC);
    step();
    i_flush = 1'b0;
    vin = 1'b0;
    rin = 1'b0;
    step();
    check("level_flush", 32'(o_level), 32'd0);
    vin = 1'b1;
    din = rgb_t'(12'h5A5);
    step();
    vin = 1'b0;
    rin = 1'b1;
    repeat (4) step();

    phase = "midreset";
    rin = 1'b0;
    vin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = rgb_t'(12'h700 + i);
      step();
    end
    vin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();

    phase = "random";
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 500; c++) begin
        vin     = ($urandom_range(99) < (p == 0 ? 80 : (p == 1 ? 30 : 55)));
        rin     = ($urandom_range(99) < (p == 0 ? 30 : (p == 1 ? 80 : 55)));
        i_flush = ($urandom_range(63) == 0);
        din     = rgb_t'($urandom);
        step();
      end
    end
    i_flush = 1'b0;
    vin = 1'b0;
    rin = 1'b1;
    repeat (DEPTH + 2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
